// File: rtl/dsync_filt.sv
// ---------------------------------------------------------------------------
// dsync_filt
//  N-channel synchroniser for asynchronous level inputs. Each channel has
//  its own stability filter and registered rise/fall pulse outputs. A new
//  synchronised level is accepted only after it has differed from the
//  current output for FILT consecutive cycles. Any earlier reversal clears
//  the channel's counter, so glitches shorter than FILT cycles are dropped.
//
//  Optional feature macro: DSYNC_DELAY_EN
//   When defined, an extra synchroniser stage is built and the input
//   dly[N-1:0] selects, per channel, whether the synchronised level is
//   taken one stage later. The bench uses this to model CDC delay.
//   When the macro is undefined, the extra stage and the dly port do not
//   exist.
// ---------------------------------------------------------------------------
module dsync_filt #(
   parameter int             N      = 4,
   parameter int             PS     = 2,
   parameter int             FILT   = 3,
   parameter logic [N-1:0]   RSTVAL = {N{1'b0}}
) (
   input  logic           clk,
   input  logic           nreset,
`ifdef DSYNC_DELAY_EN
   input  logic [N-1:0]   dly,
`endif
   input  logic [N-1:0]   din,
   output logic [N-1:0]   dout,
   output logic [N-1:0]   rise,
   output logic [N-1:0]   fall,
   output logic           any
);

   // Width of each per-channel stability counter.
   localparam int CW = $clog2(FILT + 1);

   // Number of synchroniser stages actually built.
`ifdef DSYNC_DELAY_EN
   localparam int PD = PS + 1;
`else
   localparam int PD = PS;
`endif

   // The counter's last value before acceptance, and its increment.
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   // Synchroniser pipe. Stage 0 captures din, and stage PS-1 (or PS) is the
   // synchronised level.
   logic [N-1:0]  pipe_q [PD];
   logic [N-1:0]  pipe_d [PD];

   // Per-channel filter state and registered outputs.
   logic [CW-1:0] cnt_q  [N];
   logic [CW-1:0] cnt_d  [N];
   logic [N-1:0]  dout_q;
   logic [N-1:0]  dout_d;
   logic [N-1:0]  rise_q;
   logic [N-1:0]  rise_d;
   logic [N-1:0]  fall_q;
   logic [N-1:0]  fall_d;
   logic          any_q;
   logic          any_d;

   // Synchronised level seen by each channel's filter.
   logic [N-1:0]  sync_s;

   // Shift din into the synchroniser pipe, one stage per clock.
   always_comb begin
      pipe_d[0] = din;
      for (int j = 1; j < PD; j++) begin
         pipe_d[j] = pipe_q[j-1];
      end
   end

   // Pick the synchronised level. An optional per-channel extra stage is
   // available.
`ifdef DSYNC_DELAY_EN
   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (dly[i]) begin
            sync_s[i] = pipe_q[PS][i];
         end else begin
            sync_s[i] = pipe_q[PS-1][i];
         end
      end
   end
`else
   assign sync_s = pipe_q[PS-1];
`endif

   // Stability filter. A channel's output follows its synchronised level
   // only after FILT consecutive mismatching cycles. Each acceptance
   // produces exactly one rise or fall pulse.
   always_comb begin
      dout_d = dout_q;
      rise_d = {N{1'b0}};
      fall_d = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_s[i] == dout_q[i]) begin
            cnt_d[i] = CNT_ZERO;
         end else if (cnt_q[i] == CNT_LAST) begin
            dout_d[i] = sync_s[i];
            rise_d[i] = sync_s[i];
            fall_d[i] = ~sync_s[i];
            cnt_d[i]  = CNT_ZERO;
         end else begin
            cnt_d[i]  = cnt_q[i] + CNT_ONE;
         end
      end
      any_d = |(rise_d | fall_d);
   end

   // Pipe register. It resets to RSTVAL so that releasing reset produces
   // no spurious edge.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int j = 0; j < PD; j++) begin
            pipe_q[j] <= RSTVAL;
         end
      end else begin
         for (int j = 0; j < PD; j++) begin
            pipe_q[j] <= pipe_d[j];
         end
      end
   end

   // Filter counters, accepted level and edge pulses.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
         dout_q <= RSTVAL;
         rise_q <= {N{1'b0}};
         fall_q <= {N{1'b0}};
         any_q  <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         any_q  <= any_d;
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign any  = any_q;

endmodule

// File: tb/tb_dsync_filt.sv
// ---------------------------------------------------------------------------
// tb_dsync_filt
//  Two instances: dut0 with RSTVAL=0000 carries the functional traffic, and
//  dut1 with RSTVAL=0101 checks reset level and quiet release. Stimulus
//  pushes a hand-computed event {edge number, dout, rise, fall} for every
//  expected pulse. A monitor pops and compares each time a DUT raises any
//  pulse output. A pulse with nothing queued is an error, and so are
//  entries left over at the end.
// ---------------------------------------------------------------------------
module tb_dsync_filt;

   typedef struct {
      int         cyc;
      logic [3:0] dout;
      logic [3:0] rise;
      logic [3:0] fall;
   } ev_t;

   logic       clk;
   logic       nreset;
   logic [3:0] din0, din1;
   logic [3:0] dout0, dout1, rise0, rise1, fall0, fall1;
   logic       any0, any1;
   logic [3:0] dly0, dly1;

   int  cyc;
   int  checks;
   int  errors;
   ev_t q0[$];
   ev_t q1[$];

   dsync_filt #(.N(4), .PS(2), .FILT(3), .RSTVAL(4'b0000)) dut0 (
      .clk(clk), .nreset(nreset),
`ifdef DSYNC_DELAY_EN
      .dly(dly0),
`endif
      .din(din0), .dout(dout0), .rise(rise0), .fall(fall0), .any(any0)
   );

   dsync_filt #(.N(4), .PS(2), .FILT(3), .RSTVAL(4'b0101)) dut1 (
      .clk(clk), .nreset(nreset),
`ifdef DSYNC_DELAY_EN
      .dly(dly1),
`endif
      .din(din1), .dout(dout1), .rise(rise1), .fall(fall1), .any(any1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count active edges. At a negedge, cyc holds the number of posedges so far.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Queue an expected pulse for dut0, dcyc edges after the current point.
   task automatic expect0(input int dcyc, input logic [3:0] d, input logic [3:0] r,
                          input logic [3:0] f);
      ev_t e;
      e.cyc = cyc + dcyc; e.dout = d; e.rise = r; e.fall = f;
      q0.push_back(e);
   endtask

   task automatic check_ev(input int id, input logic [3:0] d, input logic [3:0] r,
                           input logic [3:0] f, input logic a);
      ev_t e;
      int  sz;
      checks++;
      if (id == 0) sz = q0.size(); else sz = q1.size();
      if (sz == 0) begin
         errors++;
         $display("FAIL unexpected_pulse dut%0d cyc %0d dout %b rise %b fall %b any %b",
                  id, cyc, d, r, f, a);
      end else begin
         if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
         if (e.cyc != cyc || d !== e.dout || r !== e.rise || f !== e.fall || a !== 1'b1) begin
            errors++;
            $display("FAIL pulse dut%0d: got cyc %0d dout %b rise %b fall %b any %b, expected cyc %0d dout %b rise %b fall %b any 1",
                     id, cyc, d, r, f, a, e.cyc, e.dout, e.rise, e.fall);
         end
      end
   endtask

   // Monitor: any activity on the pulse outputs is matched against the queue.
   always @(negedge clk) begin
      if (nreset) begin
         if (any0 || (rise0 != 4'b0000) || (fall0 != 4'b0000))
            check_ev(0, dout0, rise0, fall0, any0);
         if (any1 || (rise1 != 4'b0000) || (fall1 != 4'b0000))
            check_ev(1, dout1, rise1, fall1, any1);
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      nreset = 1'b0;
      din0   = 4'b0000;
      din1   = 4'b0101;
      dly0   = 4'b0000;
      dly1   = 4'b0000;

      // 1: reset level, then 20 quiet cycles after release
      step(3);
      chk4("rst_dout0", dout0, 4'b0000);
      chk4("rst_dout1", dout1, 4'b0101);
      chk4("rst_pulses0", rise0 | fall0 | {3'b000, any0}, 4'b0000);
      chk4("rst_pulses1", rise1 | fall1 | {3'b000, any1}, 4'b0000);
      nreset = 1'b1;
      step(20);
      chk4("rel_dout1", dout1, 4'b0101);
      chk4("rel_dout0", dout0, 4'b0000);

      // 2: rise on bit 0 at edge PS+FILT, then the matching fall
      din0 = 4'b0001; expect0(5, 4'b0001, 4'b0001, 4'b0000);
      step(10);
      din0 = 4'b0000; expect0(5, 4'b0000, 4'b0000, 4'b0001);
      step(10);

      // 3: a 2-cycle glitch is rejected, and a 3-cycle pulse is accepted
      din0 = 4'b0010; step(2);
      din0 = 4'b0000; step(10);
      chk4("glitch_dout", dout0, 4'b0000);
      din0 = 4'b0010; expect0(5, 4'b0010, 4'b0010, 4'b0000);
      step(3);
      din0 = 4'b0000; expect0(5, 4'b0000, 4'b0000, 4'b0010);
      step(10);

      // 4: all channels together
      din0 = 4'b1111; expect0(5, 4'b1111, 4'b1111, 4'b0000);
      step(10);
      din0 = 4'b0000; expect0(5, 4'b0000, 4'b0000, 4'b1111);
      step(10);

      // 5: reset asserted mid-filter
      din0 = 4'b1000; expect0(5, 4'b1000, 4'b1000, 4'b0000);
      step(10);
      din0 = 4'b1100;
      step(4);                       // cnt[2] == 2 here
      nreset = 1'b0;
      #1;
      chk4("midrst_dout0", dout0, 4'b0000);
      chk4("midrst_dout1", dout1, 4'b0101);
      chk4("midrst_pulses0", rise0 | fall0 | {3'b000, any0}, 4'b0000);
      step(2);
      nreset = 1'b1; expect0(5, 4'b1100, 4'b1100, 4'b0000);
      step(10);

      // fast toggling on bit 0 never passes the filter
      for (int k = 0; k < 12; k++) begin
         din0[0] = ~din0[0];
         step(1);
      end
      step(10);
      chk4("toggle_dout", dout0, 4'b1100);

`ifdef DSYNC_DELAY_EN
      // 6: bit 0 takes the extra stage and lags bit 1 by one cycle
      dly0 = 4'b0001;
      step(1);
      din0 = 4'b1111;
      expect0(5, 4'b1110, 4'b0010, 4'b0000);
      expect0(6, 4'b1111, 4'b0001, 4'b0000);
      step(12);
      chk4("dly_dout", dout0, 4'b1111);
`endif

      step(5);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL missing_pulses: got %0d/%0d unconsumed expected 0/0", q0.size(), q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
